stack_pointer_unit: RTL and testbench

//   Main-stack and return-stack pointer bookkeeping for the stack datapath. Consumes the

---
 rtl/stack_pointer_unit.sv | 175 +++++++++++++++++
 tb/tb_stack_pointer_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_pointer_unit.sv
// Main-stack and return-stack pointer bookkeeping: registered pointers and occupancy,
// combinational top/second/push addresses, full/empty and sticky overflow/underflow flags.

module stack_ptr_track #(
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter int                STEP   = 2,
    parameter int                DEPTH  = 16,
    parameter int                CNT_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_write,
    input  logic              i_pop,
    input  logic              i_err_clr,
    output logic [ADDR_W-1:0] o_top,
    output logic [ADDR_W-1:0] o_push,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_ovf,
    output logic              o_unf
);

    localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_sp;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_unf;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_ovf_evt;
    logic w_unf_evt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_push_ok = i_write & ~i_pop & ~w_full;
    assign w_pop_ok  = i_write &  i_pop & ~w_empty;
    assign w_ovf_evt = i_write & ~i_pop &  w_full;
    assign w_unf_evt = i_write &  i_pop &  w_empty;

    // Stack grows downward; the pointer always addresses the current top entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sp    <= BASE;
            r_count <= '0;
        end else if (w_push_ok) begin
            r_sp    <= r_sp - STEP_A;
            r_count <= r_count + CNT_W'(1);
        end else if (w_pop_ok) begin
            r_sp    <= r_sp + STEP_A;
            r_count <= r_count - CNT_W'(1);
        end
    end

    // An error event on the same edge as a clear wins so no fault is ever lost.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (i_err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_evt) begin
                r_unf <= 1'b1;
            end else if (i_err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign o_top   = r_sp;
    assign o_push  = r_sp - STEP_A;
    assign o_count = r_count;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

    a_sp_matches_count : assert property (@(posedge i_clk) disable iff (i_rst)
        r_sp == BASE - (ADDR_W'(r_count) * STEP_A));

endmodule

module stack_pointer_unit #(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] MS_BASE = 16'h8000,
    parameter logic [ADDR_W-1:0] RS_BASE = 16'hC000,
    parameter int                STEP    = 2,
    parameter int                DEPTH   = 16,
    parameter int                CNT_W   = 5
) (
    input  logic              CLK,
    input  logic              CtrlRst,
    input  logic              MSPWrite,
    input  logic              MSPop,
    input  logic              RSPWrite,
    input  logic              RSPop,
    input  logic              ErrClr,
    output logic [ADDR_W-1:0] MSTop,
    output logic [ADDR_W-1:0] MSSecond,
    output logic [ADDR_W-1:0] MSPush,
    output logic [ADDR_W-1:0] RSTop,
    output logic [ADDR_W-1:0] RSPush,
    output logic [CNT_W-1:0]  MSCount,
    output logic [CNT_W-1:0]  RSCount,
    output logic              MSEmpty,
    output logic              MSFull,
    output logic              RSEmpty,
    output logic              RSFull,
    output logic              MSOvf,
    output logic              MSUnf,
    output logic              RSOvf,
    output logic              RSUnf
);

    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

    logic [ADDR_W-1:0] w_ms_top;

    stack_ptr_track #(
        .ADDR_W (ADDR_W),
        .BASE   (MS_BASE),
        .STEP   (STEP),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_ms (
        .i_clk     (CLK),
        .i_rst     (CtrlRst),
        .i_write   (MSPWrite),
        .i_pop     (MSPop),
        .i_err_clr (ErrClr),
        .o_top     (w_ms_top),
        .o_push    (MSPush),
        .o_count   (MSCount),
        .o_empty   (MSEmpty),
        .o_full    (MSFull),
        .o_ovf     (MSOvf),
        .o_unf     (MSUnf)
    );

    stack_ptr_track #(
        .ADDR_W (ADDR_W),
        .BASE   (RS_BASE),
        .STEP   (STEP),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_rs (
        .i_clk     (CLK),
        .i_rst     (CtrlRst),
        .i_write   (RSPWrite),
        .i_pop     (RSPop),
        .i_err_clr (ErrClr),
        .o_top     (RSTop),
        .o_push    (RSPush),
        .o_count   (RSCount),
        .o_empty   (RSEmpty),
        .o_full    (RSFull),
        .o_ovf     (RSOvf),
        .o_unf     (RSUnf)
    );

    // With fewer than two entries this address is meaningless but harmless.
    assign MSTop    = w_ms_top;
    assign MSSecond = w_ms_top + STEP_A;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Scoreboard bench for stack_pointer_unit: stimulus queues hand-computed expectations,
// a monitor compares them one clock edge later.

module tb_stack_pointer_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ms_w, ms_p, rs_w, rs_p, clr;
    logic [15:0] ms_top, ms_second, ms_push, rs_top, rs_push;
    logic [4:0]  ms_cnt, rs_cnt;
    logic        ms_empty, ms_full, rs_empty, rs_full;
    logic        ms_ovf, ms_unf, rs_ovf, rs_unf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] ms_top;
        logic [4:0]  ms_cnt;
        logic [15:0] rs_top;
        logic [4:0]  rs_cnt;
        logic [3:0]  err;    // {MSOvf, MSUnf, RSOvf, RSUnf}
    } exp_t;

    exp_t q[$];

    logic [4:0] m_msc, m_rsc;
    logic [3:0] m_err;

    stack_pointer_unit dut (
        .CLK      (clk),
        .CtrlRst  (rst),
        .MSPWrite (ms_w),
        .MSPop    (ms_p),
        .RSPWrite (rs_w),
        .RSPop    (rs_p),
        .ErrClr   (clr),
        .MSTop    (ms_top),
        .MSSecond (ms_second),
        .MSPush   (ms_push),
        .RSTop    (rs_top),
        .RSPush   (rs_push),
        .MSCount  (ms_cnt),
        .RSCount  (rs_cnt),
        .MSEmpty  (ms_empty),
        .MSFull   (ms_full),
        .RSEmpty  (rs_empty),
        .RSFull   (rs_full),
        .MSOvf    (ms_ovf),
        .MSUnf    (ms_unf),
        .RSOvf    (rs_ovf),
        .RSUnf    (rs_unf)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input exp_t e);
        cmp("MSTop",    ms_top,            e.ms_top);
        cmp("MSPush",   ms_push,           e.ms_top - 16'd2);
        if (e.ms_cnt >= 5'd2) cmp("MSSecond", ms_second, e.ms_top + 16'd2);
        cmp("MSCount",  16'(ms_cnt),       16'(e.ms_cnt));
        cmp("MSEmpty",  16'(ms_empty),     16'(e.ms_cnt == 5'd0));
        cmp("MSFull",   16'(ms_full),      16'(e.ms_cnt == 5'd16));
        cmp("RSTop",    rs_top,            e.rs_top);
        cmp("RSPush",   rs_push,           e.rs_top - 16'd2);
        cmp("RSCount",  16'(rs_cnt),       16'(e.rs_cnt));
        cmp("RSEmpty",  16'(rs_empty),     16'(e.rs_cnt == 5'd0));
        cmp("RSFull",   16'(rs_full),      16'(e.rs_cnt == 5'd16));
        cmp("ErrFlags", 16'({ms_ovf, ms_unf, rs_ovf, rs_unf}), 16'(e.err));
    endtask

    // Monitor: the state produced by each stimulus edge is visible just after that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_all(e);
            end
        end
    end

    task automatic step(input logic msw, input logic msp, input logic rsw, input logic rsp,
                        input logic c, input logic [15:0] mst, input logic [4:0] msc,
                        input logic [15:0] rstop, input logic [4:0] rsc, input logic [3:0] err);
        exp_t e;
        @(negedge clk);
        ms_w = msw; ms_p = msp; rs_w = rsw; rs_p = rsp; clr = c;
        e.ms_top = mst; e.ms_cnt = msc; e.rs_top = rstop; e.rs_cnt = rsc; e.err = err;
        q.push_back(e);
    endtask

    // Reference model used for the randomised run: pointer is always BASE - 2*count.
    task automatic mstep(input logic msw, input logic msp, input logic rsw, input logic rsp,
                         input logic c);
        logic mo, mu, ro, ru;
        mo = msw & ~msp & (m_msc == 5'd16);
        mu = msw &  msp & (m_msc == 5'd0);
        ro = rsw & ~rsp & (m_rsc == 5'd16);
        ru = rsw &  rsp & (m_rsc == 5'd0);
        if (msw & ~msp & ~mo) m_msc = m_msc + 5'd1;
        if (msw &  msp & ~mu) m_msc = m_msc - 5'd1;
        if (rsw & ~rsp & ~ro) m_rsc = m_rsc + 5'd1;
        if (rsw &  rsp & ~ru) m_rsc = m_rsc - 5'd1;
        m_err[3] = mo | (~c & m_err[3]);
        m_err[2] = mu | (~c & m_err[2]);
        m_err[1] = ro | (~c & m_err[1]);
        m_err[0] = ru | (~c & m_err[0]);
        step(msw, msp, rsw, rsp, c,
             16'h8000 - 16'(m_msc) * 16'd2, m_msc,
             16'hC000 - 16'(m_rsc) * 16'd2, m_rsc, m_err);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        exp_t rexp;
        rexp.ms_top = 16'h8000; rexp.ms_cnt = 5'd0;
        rexp.rs_top = 16'hC000; rexp.rs_cnt = 5'd0; rexp.err = 4'b0000;

        rst = 1'b1; ms_w = 0; ms_p = 0; rs_w = 0; rs_p = 0; clr = 0;
        #2;
        check_all(rexp);
        #10;
        rst = 1'b0;

        // Idle, then three main-stack pushes.
        step(0, 0, 0, 0, 0, 16'h8000, 5'd0, 16'hC000, 5'd0, 4'b0000);
        step(1, 0, 0, 0, 0, 16'h7FFE, 5'd1, 16'hC000, 5'd0, 4'b0000);
        step(1, 0, 0, 0, 0, 16'h7FFC, 5'd2, 16'hC000, 5'd0, 4'b0000);
        step(1, 0, 0, 0, 0, 16'h7FFA, 5'd3, 16'hC000, 5'd0, 4'b0000);

        // Fill to 16, then overflow.
        for (int i = 4; i <= 16; i++)
            step(1, 0, 0, 0, 0, 16'h8000 - 16'(2 * i), 5'(i), 16'hC000, 5'd0, 4'b0000);
        step(1, 0, 0, 0, 0, 16'h7FE0, 5'd16, 16'hC000, 5'd0, 4'b1000);
        // Clear coinciding with another overflow keeps the flag; a lone clear drops it.
        step(1, 0, 0, 0, 1, 16'h7FE0, 5'd16, 16'hC000, 5'd0, 4'b1000);
        step(0, 0, 0, 0, 1, 16'h7FE0, 5'd16, 16'hC000, 5'd0, 4'b0000);
        // Write strobe low: pop request ignored.
        step(0, 1, 0, 1, 0, 16'h7FE0, 5'd16, 16'hC000, 5'd0, 4'b0000);

        for (int i = 15; i >= 0; i--)
            step(1, 1, 0, 0, 0, 16'h8000 - 16'(2 * i), 5'(i), 16'hC000, 5'd0, 4'b0000);

        // Return-stack underflow, then clear.
        step(0, 0, 1, 1, 0, 16'h8000, 5'd0, 16'hC000, 5'd0, 4'b0001);
        step(0, 0, 0, 0, 1, 16'h8000, 5'd0, 16'hC000, 5'd0, 4'b0000);

        // Concurrent updates on both stacks.
        step(1, 0, 1, 0, 0, 16'h7FFE, 5'd1, 16'hBFFE, 5'd1, 4'b0000);
        step(1, 1, 1, 0, 0, 16'h8000, 5'd0, 16'hBFFC, 5'd2, 4'b0000);
        step(1, 1, 1, 0, 0, 16'h8000, 5'd0, 16'hBFFA, 5'd3, 4'b0100);
        step(1, 0, 1, 1, 0, 16'h7FFE, 5'd1, 16'hBFFC, 5'd2, 4'b0100);
        step(0, 0, 0, 0, 0, 16'h7FFE, 5'd1, 16'hBFFC, 5'd2, 4'b0100);
        drain();

        // Asynchronous reset between edges takes effect without a clock edge.
        rst = 1'b1;
        #1;
        check_all(rexp);
        #1;
        rst = 1'b0;

        m_msc = 5'd0; m_rsc = 5'd0; m_err = 4'b0000;
        for (int i = 0; i < 300; i++)
            mstep(1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
        for (int i = 0; i < 40; i++)
            mstep(1'b1, 1'b1, 1'b1, 1'($urandom), 1'b0);
        mstep(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
